// File: rtl/time_set_ctrl_if.sv
// ---------------------------------------------------------------------------------------------
// time_set_ctrl_if
//   Bus between the front-panel time-setting controller and the clock core.
//   The controller (master) reads the running time and drives the edited time,
//   the mode flags and the one-cycle load strobe. The clock core (slave) is the other end.
//
//   cur_hour_tens/ones, cur_min_tens/ones  running BCD time from the clock core
//   set_active                             clock core freezes its counters while high
//   sel_hour, sel_min                      digit-blink selects
//   hour_tens/ones, min_tens/ones          edited BCD time, valid while load=1
//   load                                   one-cycle commit strobe
// ---------------------------------------------------------------------------------------------
interface time_set_ctrl_if;
    logic [3:0] cur_hour_tens;
    logic [3:0] cur_hour_ones;
    logic [3:0] cur_min_tens;
    logic [3:0] cur_min_ones;
    logic       set_active;
    logic       sel_hour;
    logic       sel_min;
    logic [3:0] hour_tens;
    logic [3:0] hour_ones;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic       load;

    modport master (
        input  cur_hour_tens, cur_hour_ones, cur_min_tens, cur_min_ones,
        output set_active, sel_hour, sel_min,
        output hour_tens, hour_ones, min_tens, min_ones, load
    );

    modport slave (
        output cur_hour_tens, cur_hour_ones, cur_min_tens, cur_min_ones,
        input  set_active, sel_hour, sel_min,
        input  hour_tens, hour_ones, min_tens, min_ones, load
    );
endinterface

// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------------------------
// time_set_ctrl
//   Front-panel time-setting controller for a 12-hour digital clock.
//   Two raw push-buttons (MODE, INC) are synchronised and debounced into one-cycle press
//   pulses. A RUN -> SET_HOUR -> SET_MIN -> COMMIT state machine edits a BCD copy of the
//   running time and, on commit, pulses load for one cycle with the new HH:MM.
//   An idle SET_* state times out back to RUN without loading.
//
//   clk        main clock, all logic on posedge
//   reset      asynchronous active-low master reset
//   btn_mode   raw MODE button, active-high, asynchronous to clk
//   btn_inc    raw INC button, active-high, asynchronous to clk
//   bus        time_set_ctrl_if master modport (running time in, edited time/strobes out)
// ---------------------------------------------------------------------------------------------
module time_set_ctrl #(
    parameter int unsigned DB_CYCLES      = 50000,
    parameter int unsigned DB_W           = 16,
    parameter int unsigned TIMEOUT_CYCLES = 10000000,
    parameter int unsigned TO_W           = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_mode,
    input  logic             btn_inc,
    time_set_ctrl_if.master  bus
);

    localparam logic [DB_W-1:0] DbLast = DB_W'(DB_CYCLES - 1);
    localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StRun,
        StSetHour,
        StSetMin,
        StCommit
    } state_e;

    // -----------------------------------------------------------------------------------------
    // Input conditioning. Index 0 is MODE, index 1 is INC.
    // -----------------------------------------------------------------------------------------
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [1:0]            stable_q, stable_d;
    logic [1:0]            stable_dly_q, stable_dly_d;
    logic [1:0]            press_q, press_d;

    logic mode_press;
    logic inc_press;

    // The counter runs while the synchronised level disagrees with the accepted level, so a
    // new level is accepted only after DB_CYCLES consecutive identical samples; any sample
    // that agrees again with the old level restarts the count.
    always_comb begin
        sync1_d      = {btn_inc, btn_mode};
        sync2_d      = sync1_q;
        db_cnt_d     = db_cnt_q;
        stable_d     = stable_q;
        stable_dly_d = stable_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DbLast) begin
                stable_d[i] = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
        // Rising edge of the accepted level only; releases are ignored.
        press_d = stable_q & ~stable_dly_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            db_cnt_q     <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            press_q      <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_cnt_q     <= db_cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            press_q      <= press_d;
        end
    end

    assign mode_press = press_q[0];
    assign inc_press  = press_q[1];

    // -----------------------------------------------------------------------------------------
    // Edit state machine
    // -----------------------------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [3:0]      hour_tens_q, hour_tens_d;
    logic [3:0]      hour_ones_q, hour_ones_d;
    logic [3:0]      min_tens_q, min_tens_d;
    logic [3:0]      min_ones_q, min_ones_d;
    logic            set_active_q, set_active_d;
    logic            sel_hour_q, sel_hour_d;
    logic            sel_min_q, sel_min_d;
    logic            load_q, load_d;

    logic            cur_hour_ok;
    logic            cur_min_ok;

    // Snapshot sanity: hour must be BCD 01..12, minute BCD 00..59.
    always_comb begin
        cur_hour_ok = ((bus.cur_hour_tens == 4'd0) && (bus.cur_hour_ones >= 4'd1) &&
                       (bus.cur_hour_ones <= 4'd9)) ||
                      ((bus.cur_hour_tens == 4'd1) && (bus.cur_hour_ones <= 4'd2));
        cur_min_ok  = (bus.cur_min_tens <= 4'd5) && (bus.cur_min_ones <= 4'd9);
    end

    always_comb begin
        state_d     = state_q;
        to_cnt_d    = to_cnt_q;
        hour_tens_d = hour_tens_q;
        hour_ones_d = hour_ones_q;
        min_tens_d  = min_tens_q;
        min_ones_d  = min_ones_q;

        unique case (state_q)
            StRun: begin
                to_cnt_d = '0;
                if (mode_press) begin
                    state_d = StSetHour;
                    if (cur_hour_ok) begin
                        hour_tens_d = bus.cur_hour_tens;
                        hour_ones_d = bus.cur_hour_ones;
                    end else begin
                        hour_tens_d = 4'd0;
                        hour_ones_d = 4'd1;
                    end
                    if (cur_min_ok) begin
                        min_tens_d = bus.cur_min_tens;
                        min_ones_d = bus.cur_min_ones;
                    end else begin
                        min_tens_d = 4'd0;
                        min_ones_d = 4'd0;
                    end
                end
            end

            StSetHour: begin
                // MODE outranks both INC and the timeout.
                if (mode_press) begin
                    state_d  = StSetMin;
                    to_cnt_d = '0;
                end else if (inc_press) begin
                    to_cnt_d = '0;
                    if ((hour_tens_q == 4'd1) && (hour_ones_q == 4'd2)) begin
                        hour_tens_d = 4'd0;
                        hour_ones_d = 4'd1;
                    end else if (hour_ones_q == 4'd9) begin
                        hour_tens_d = hour_tens_q + 4'd1;
                        hour_ones_d = 4'd0;
                    end else begin
                        hour_ones_d = hour_ones_q + 4'd1;
                    end
                end else if (to_cnt_q == ToLast) begin
                    state_d  = StRun;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            StSetMin: begin
                if (mode_press) begin
                    state_d  = StCommit;
                    to_cnt_d = '0;
                end else if (inc_press) begin
                    to_cnt_d = '0;
                    // Minute wraps 59 -> 00 with no carry into the hour.
                    if (min_ones_q == 4'd9) begin
                        min_ones_d = 4'd0;
                        min_tens_d = (min_tens_q == 4'd5) ? 4'd0 : min_tens_q + 4'd1;
                    end else begin
                        min_ones_d = min_ones_q + 4'd1;
                    end
                end else if (to_cnt_q == ToLast) begin
                    state_d  = StRun;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            StCommit: begin
                state_d  = StRun;
                to_cnt_d = '0;
            end

            default: begin
                state_d  = StRun;
                to_cnt_d = '0;
            end
        endcase

        // Flags are registered from the next state so they line up with state_q.
        set_active_d = (state_d != StRun);
        sel_hour_d   = (state_d == StSetHour);
        sel_min_d    = (state_d == StSetMin);
        load_d       = (state_d == StCommit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StRun;
            to_cnt_q     <= '0;
            hour_tens_q  <= 4'd0;
            hour_ones_q  <= 4'd1;
            min_tens_q   <= 4'd0;
            min_ones_q   <= 4'd0;
            set_active_q <= 1'b0;
            sel_hour_q   <= 1'b0;
            sel_min_q    <= 1'b0;
            load_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            to_cnt_q     <= to_cnt_d;
            hour_tens_q  <= hour_tens_d;
            hour_ones_q  <= hour_ones_d;
            min_tens_q   <= min_tens_d;
            min_ones_q   <= min_ones_d;
            set_active_q <= set_active_d;
            sel_hour_q   <= sel_hour_d;
            sel_min_q    <= sel_min_d;
            load_q       <= load_d;
        end
    end

    assign bus.set_active = set_active_q;
    assign bus.sel_hour   = sel_hour_q;
    assign bus.sel_min    = sel_min_q;
    assign bus.load       = load_q;
    assign bus.hour_tens  = hour_tens_q;
    assign bus.hour_ones  = hour_ones_q;
    assign bus.min_tens   = min_tens_q;
    assign bus.min_ones   = min_ones_q;

endmodule
